// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART link:
//   uart_state_t  - state encoding used by both the TX and RX FSMs
//   PARITY_*      - parity mode constants for the PARITY parameter
//   calc_div()    - clock cycles per 16x oversample tick, rounded to nearest
//   parity_bit()  - parity bit over the low nbits of a payload
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // round(clk_hz / (16 * baud)) done in integer arithmetic
   function automatic int calc_div(input int clk_hz, input int baud);
      longint num;
      longint den;
      num = longint'(clk_hz) + 64'sd8 * longint'(baud);
      den = 64'sd16 * longint'(baud);
      return int'(num / den);
   endfunction

   // Even mode returns the XOR of the payload, odd mode its complement, so
   // that payload plus parity bit carries an even / odd number of ones.
   function automatic logic parity_bit(input logic [8:0] data, input int nbits,
                                       input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return (mode == PARITY_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Show-ahead FIFO holding received frames.
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (empties the FIFO)
//   i_push       write i_push_data (dropped when full unless popping too)
//   i_push_data  WIDTH-bit entry
//   i_pop        remove head entry (ignored when empty)
//   o_data       head entry, meaningful only while o_valid is high
//   o_valid      FIFO not empty
//   o_overrun    one-cycle pulse when a push is dropped
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);

   localparam int AW = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
         $error("uart_fifo: DEPTH must be a power of two in 2..64");
      end
   endgenerate

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_overrun;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_do_push = i_push && (!w_full || w_do_pop);

   // Storage needs no reset; the read is combinational so the head is
   // visible without a read request.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         r_overrun <= i_push && !w_do_push;
      end
   end

   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign o_valid   = !w_empty;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_link.sv
// -----------------------------------------------------------------------------
// uart_link
// Full-duplex UART: transmitter, 16x oversampling receiver and RX FIFO.
//   clk_50m        clock, rising edge
//   rst            asynchronous active-low reset, aborts both directions
//   tx_data        payload to send, LSB first on the line
//   tx_wr_en       one-cycle send request, honoured only when idle
//   tx_busy        high while a TX frame is on the line
//   Tx             serial output, idle high
//   Rx             serial input (asynchronous), idle high
//   rx_data        head of RX FIFO
//   rx_valid       RX FIFO not empty
//   rx_rd_en       pop RX FIFO head
//   rx_frame_err   pulse: first stop bit sampled low
//   rx_parity_err  pulse: parity mismatch
//   rx_overrun     pulse: good frame dropped because FIFO full
// -----------------------------------------------------------------------------
module uart_link
   import uart_pkg::*;
#(
   parameter int CLK_HZ        = 50000000,
   parameter int BAUD          = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr_en,
   output logic                 tx_busy,
   output logic                 Tx,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_rd_en,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int DIV     = calc_div(CLK_HZ, BAUD);
   localparam int BIT_CYC = 16 * DIV;
   localparam int DIV_W   = $clog2(DIV + 1);
   localparam int BIT_W   = $clog2(BIT_CYC + 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_link: CLK_HZ/(16*BAUD) rounds below 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
         $error("uart_link: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_par_check
         $error("uart_link: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
         $error("uart_link: STOP_BITS must be 1 or 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Free-running oversample tick (drives the receiver)
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] r_baud_cnt;
   logic             w_tick;

   assign w_tick = (r_baud_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk_50m or negedge rst) begin
      if (!rst)        r_baud_cnt <= '0;
      else if (w_tick) r_baud_cnt <= '0;
      else             r_baud_cnt <= r_baud_cnt + DIV_W'(1);
   end

   // ------------------------------------------------------------------
   // Transmitter. Its bit timer counts raw clocks from the acceptance edge
   // so the start bit is exactly one bit period long, independent of the
   // phase of the shared oversample tick.
   // ------------------------------------------------------------------
   uart_state_t          r_tx_state;
   uart_state_t          w_tx_state_next;
   logic [BIT_W-1:0]     r_tx_cnt;
   logic [3:0]           r_tx_idx;
   logic [DATA_BITS-1:0] r_tx_data;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 w_tx_bit_done;
   logic                 w_tx_accept;

   assign w_tx_bit_done = (r_tx_cnt == BIT_W'(BIT_CYC - 1));
   assign w_tx_accept   = (r_tx_state == ST_IDLE) && tx_wr_en;

   always_ff @(posedge clk_50m or negedge rst) begin
      if (!rst) begin
         r_tx_state <= ST_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_data  <= '0;
         r_tx_shift <= '0;
      end else begin
         r_tx_state <= w_tx_state_next;
         if (r_tx_state == ST_IDLE || w_tx_bit_done) r_tx_cnt <= '0;
         else                                        r_tx_cnt <= r_tx_cnt + BIT_W'(1);
         // bit index counts bits within DATA and STOP; cleared on every state change
         if (w_tx_state_next != r_tx_state) r_tx_idx <= '0;
         else if (w_tx_bit_done)            r_tx_idx <= r_tx_idx + 4'd1;
         if (w_tx_accept) begin
            r_tx_data  <= tx_data;
            r_tx_shift <= tx_data;
         end else if (r_tx_state == ST_DATA && w_tx_bit_done) begin
            r_tx_shift <= r_tx_shift >> 1;
         end
      end
   end

   always_comb begin
      w_tx_state_next = r_tx_state;
      case (r_tx_state)
         ST_IDLE:   if (tx_wr_en) w_tx_state_next = ST_START;
         ST_START:  if (w_tx_bit_done) w_tx_state_next = ST_DATA;
         ST_DATA:
            if (w_tx_bit_done && r_tx_idx == 4'(DATA_BITS - 1))
               w_tx_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_tx_bit_done) w_tx_state_next = ST_STOP;
         ST_STOP:
            if (w_tx_bit_done && r_tx_idx == 4'(STOP_BITS - 1))
               w_tx_state_next = ST_IDLE;
         default:   w_tx_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      Tx      = 1'b1;
      tx_busy = (r_tx_state != ST_IDLE);
      case (r_tx_state)
         ST_START:  Tx = 1'b0;
         ST_DATA:   Tx = r_tx_shift[0];
         ST_PARITY: Tx = parity_bit(9'(r_tx_data), DATA_BITS, PARITY);
         default:   Tx = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Receiver input conditioning
   // ------------------------------------------------------------------
   logic [1:0] r_rx_sync;
   logic [1:0] r_rx_arm;
   logic       r_rx_prev;
   logic       w_rx_line;
   logic       w_rx_fall;

   assign w_rx_line = r_rx_sync[1];
   assign w_rx_fall = r_rx_prev && !w_rx_line;

   // The synchroniser comes out of reset holding 1s, which is not the real
   // line level. r_rx_prev is held low until both flops carry sampled line
   // values, so a line already low at release never looks like a start bit.
   always_ff @(posedge clk_50m or negedge rst) begin
      if (!rst) begin
         r_rx_sync <= 2'b11;
         r_rx_arm  <= 2'd0;
         r_rx_prev <= 1'b0;
      end else begin
         r_rx_sync <= {r_rx_sync[0], Rx};
         if (r_rx_arm != 2'd2) r_rx_arm <= r_rx_arm + 2'd1;
         r_rx_prev <= (r_rx_arm == 2'd2) ? w_rx_line : 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   uart_state_t          r_rx_state;
   uart_state_t          w_rx_state_next;
   logic [3:0]           r_rx_tick;
   logic [3:0]           r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 r_rx_par_bad;
   logic                 r_rx_brk;
   logic                 r_rx_push;
   logic                 r_rx_ferr;
   logic                 r_rx_perr;
   logic                 w_rx_mid;
   logic                 w_rx_push_set;
   logic                 w_rx_ferr_set;
   logic                 w_rx_perr_set;

   // The tick counter starts at 0 on the falling edge; the 8th tick lands in
   // mid start bit and, since it wraps every 16 ticks, every later "count 7"
   // tick lands in the middle of the following bits.
   assign w_rx_mid = w_tick && (r_rx_tick == 4'd7);

   always_ff @(posedge clk_50m or negedge rst) begin
      if (!rst) begin
         r_rx_state   <= ST_IDLE;
         r_rx_tick    <= '0;
         r_rx_idx     <= '0;
         r_rx_shift   <= '0;
         r_rx_par_bad <= 1'b0;
         r_rx_brk     <= 1'b0;
         r_rx_push    <= 1'b0;
         r_rx_ferr    <= 1'b0;
         r_rx_perr    <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_next;
         if (r_rx_state == ST_IDLE) r_rx_tick <= '0;
         else if (w_tick)           r_rx_tick <= r_rx_tick + 4'd1;
         if (r_rx_state == ST_IDLE) begin
            r_rx_idx     <= '0;
            r_rx_par_bad <= 1'b0;
            r_rx_brk     <= 1'b0;
         end else begin
            if (r_rx_state == ST_DATA && w_rx_mid) begin
               r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
               r_rx_idx   <= r_rx_idx + 4'd1;
            end
            if (r_rx_state == ST_PARITY && w_rx_mid)
               r_rx_par_bad <= (w_rx_line != parity_bit(9'(r_rx_shift), DATA_BITS, PARITY));
            if (w_rx_ferr_set) r_rx_brk <= 1'b1;
         end
         r_rx_push <= w_rx_push_set;
         r_rx_ferr <= w_rx_ferr_set;
         r_rx_perr <= w_rx_perr_set;
      end
   end

   always_comb begin
      w_rx_state_next = r_rx_state;
      case (r_rx_state)
         ST_IDLE:   if (w_rx_fall) w_rx_state_next = ST_START;
         ST_START:  if (w_rx_mid) w_rx_state_next = w_rx_line ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (w_rx_mid && r_rx_idx == 4'(DATA_BITS - 1))
               w_rx_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_rx_mid) w_rx_state_next = ST_STOP;
         ST_STOP: begin
            // after a framing error, hold here until the line returns high
            if (r_rx_brk) begin
               if (w_rx_line) w_rx_state_next = ST_IDLE;
            end else if (w_rx_mid) begin
               w_rx_state_next = w_rx_line ? ST_IDLE : ST_STOP;
            end
         end
         default:   w_rx_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rx_push_set = 1'b0;
      w_rx_ferr_set = 1'b0;
      w_rx_perr_set = 1'b0;
      if (r_rx_state == ST_STOP && !r_rx_brk && w_rx_mid) begin
         w_rx_ferr_set = !w_rx_line;
         w_rx_perr_set = w_rx_line && r_rx_par_bad;
         w_rx_push_set = w_rx_line && !r_rx_par_bad;
      end
   end

   assign rx_frame_err  = r_rx_ferr;
   assign rx_parity_err = r_rx_perr;

   // r_rx_shift is stable for the push cycle: a new frame cannot reach DATA
   // within one clock of the stop-bit sample.
   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .i_clk       (clk_50m),
      .i_rst_n     (rst),
      .i_push      (r_rx_push),
      .i_push_data (r_rx_shift),
      .i_pop       (rx_rd_en),
      .o_data      (rx_data),
      .o_valid     (rx_valid),
      .o_overrun   (rx_overrun)
   );

endmodule

// File: tb/tb_uart_link.sv
// -----------------------------------------------------------------------------
// tb_uart_link
// Two instances: u_dut with default parameters (Rx driven by the bench) and
// u_par with 7 data bits / odd parity (Rx looped from its own Tx or driven).
// Expected RX payloads go into per-instance queues when frames are sent and
// are popped when the FIFO presents data; expected TX line levels likewise.
// -----------------------------------------------------------------------------
module tb_uart_link;

   localparam int BIT = 432;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   // default instance
   logic [7:0] tx_data = 8'h00;
   logic       tx_wr_en = 1'b0;
   logic       tx_busy;
   logic       tx_line;
   logic       rx_line = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rd_en = 1'b0;
   logic       ferr, perr, ovr;

   // 7-bit odd-parity instance
   logic [6:0] p_tx_data = 7'h00;
   logic       p_tx_wr_en = 1'b0;
   logic       p_tx_busy;
   logic       p_tx_line;
   logic       p_loop = 1'b0;
   logic       p_rx_line = 1'b1;
   logic       p_rx_in;
   logic [6:0] p_rx_data;
   logic       p_rx_valid;
   logic       p_rx_rd_en = 1'b0;
   logic       p_ferr, p_perr, p_ovr;

   assign p_rx_in = p_loop ? p_tx_line : p_rx_line;

   uart_link u_dut (
      .clk_50m(clk), .rst(rst_n), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
      .tx_busy(tx_busy), .Tx(tx_line), .Rx(rx_line), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_rd_en(rx_rd_en), .rx_frame_err(ferr),
      .rx_parity_err(perr), .rx_overrun(ovr)
   );

   uart_link #(.DATA_BITS(7), .PARITY(2)) u_par (
      .clk_50m(clk), .rst(rst_n), .tx_data(p_tx_data), .tx_wr_en(p_tx_wr_en),
      .tx_busy(p_tx_busy), .Tx(p_tx_line), .Rx(p_rx_in), .rx_data(p_rx_data),
      .rx_valid(p_rx_valid), .rx_rd_en(p_rx_rd_en), .rx_frame_err(p_ferr),
      .rx_parity_err(p_perr), .rx_overrun(p_ovr)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
   int p_ferr_cnt = 0, p_perr_cnt = 0, p_ovr_cnt = 0;

   logic [8:0] rx_exp_q[$];
   logic [8:0] p_exp_q[$];
   logic       tx_exp_q[$];

   // pulse counters: a pulse longer than one cycle counts more than once
   always @(negedge clk) begin
      if (ferr)   ferr_cnt++;
      if (perr)   perr_cnt++;
      if (ovr)    ovr_cnt++;
      if (p_ferr) p_ferr_cnt++;
      if (p_perr) p_perr_cnt++;
      if (p_ovr)  p_ovr_cnt++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx_line = v;
      else          p_rx_line = v;
   endtask

   task automatic send_rx_frame(input int sel, input logic [8:0] d, input int nbits,
                                input bit has_par, input logic par, input logic stop_lvl);
      set_line(sel, 1'b0);
      repeat (BIT) step();
      for (int b = 0; b < nbits; b++) begin
         set_line(sel, d[b]);
         repeat (BIT) step();
      end
      if (has_par) begin
         set_line(sel, par);
         repeat (BIT) step();
      end
      set_line(sel, stop_lvl);
      repeat (BIT) step();
      set_line(sel, 1'b1);
   endtask

   // drain the selected FIFO against its expectation queue
   task automatic read_fifo(input int sel, input string tag);
      int q_left;
      q_left = (sel == 0) ? rx_exp_q.size() : p_exp_q.size();
      while (q_left > 0) begin
         logic [8:0] e_val;
         logic [8:0] g_val;
         bit         seen;
         seen = 1'b0;
         for (int t = 0; t < 200; t++) begin
            if ((sel == 0) ? rx_valid : p_rx_valid) begin
               seen = 1'b1;
               break;
            end
            step();
         end
         if (sel == 0) e_val = rx_exp_q.pop_front();
         else          e_val = p_exp_q.pop_front();
         n_tests++;
         if (!seen) begin
            n_fail++;
            $display("FAIL %s_valid: rx_valid got 0 want 1 (data %h)", tag, e_val);
         end else begin
            g_val = (sel == 0) ? 9'(rx_data) : 9'(p_rx_data);
            if (g_val !== e_val) begin
               n_fail++;
               $display("FAIL %s_data: rx_data got %h want %h", tag, g_val, e_val);
            end
            if (sel == 0) rx_rd_en = 1'b1;
            else          p_rx_rd_en = 1'b1;
            step();
            rx_rd_en   = 1'b0;
            p_rx_rd_en = 1'b0;
         end
         q_left = (sel == 0) ? rx_exp_q.size() : p_exp_q.size();
      end
      n_tests++;
      if (((sel == 0) ? rx_valid : p_rx_valid) !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_empty: rx_valid got 1 want 0", tag);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_tests++;
      if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset_tx: Tx got %b want 1", tx_line); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: tx_busy got %b want 0", tx_busy); end
      n_tests++;
      if (rx_valid !== 1'b0 || p_rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: rx_valid got %b/%b want 0/0", rx_valid, p_rx_valid);
      end
      n_tests++;
      if ({ferr, perr, ovr} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: flags got %b want 000", {ferr, perr, ovr});
      end
      rst_n = 1'b1;
      repeat (5) step();
   endtask

   // one TX frame on the default instance; optional poke while busy
   task automatic test_tx_frame(input logic [7:0] d, input bit poke, input string tag);
      int   busy_cycles;
      logic t0, t_last_start, t_first_data;
      tx_exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) tx_exp_q.push_back(d[b]);
      tx_exp_q.push_back(1'b1);
      busy_cycles = 0;
      t0 = 1'bx; t_last_start = 1'bx; t_first_data = 1'bx;
      tx_data  = d;
      tx_wr_en = 1'b1;
      step();
      tx_wr_en = 1'b0;
      for (int i = 0; i < 10 * BIT + 20; i++) begin
         if (tx_busy === 1'b1) busy_cycles++;
         if (i == 0)       t0 = tx_line;
         if (i == BIT - 1) t_last_start = tx_line;
         if (i == BIT)     t_first_data = tx_line;
         if (i % BIT == BIT / 2 && i < 10 * BIT) begin
            logic e_bit;
            e_bit = tx_exp_q.pop_front();
            n_tests++;
            if (tx_line !== e_bit) begin
               n_fail++;
               $display("FAIL %s_bit%0d: Tx got %b want %b", tag, i / BIT, tx_line, e_bit);
            end
         end
         if (poke && i == 1000) begin
            tx_data  = ~d;
            tx_wr_en = 1'b1;
         end
         if (i == 1001) tx_wr_en = 1'b0;
         step();
      end
      tx_data = d;
      n_tests++;
      if (t0 !== 1'b0 || t_last_start !== 1'b0) begin
         n_fail++; $display("FAIL %s_start_len: Tx got %b,%b want 0,0", tag, t0, t_last_start);
      end
      n_tests++;
      if (t_first_data !== d[0]) begin
         n_fail++; $display("FAIL %s_start_end: Tx got %b want %b", tag, t_first_data, d[0]);
      end
      n_tests++;
      if (busy_cycles != 10 * BIT) begin
         n_fail++; $display("FAIL %s_busy_len: tx_busy cycles got %0d want %0d", tag, busy_cycles, 10 * BIT);
      end
   endtask

   task automatic test_parity_loopback();
      logic par_seen;
      bit   got_valid;
      int   pe0, fe0;
      pe0 = p_perr_cnt; fe0 = p_ferr_cnt;
      par_seen = 1'bx;
      got_valid = 1'b0;
      p_loop = 1'b1;
      repeat (5) step();
      p_exp_q.push_back(9'h055);
      p_tx_data  = 7'h55;
      p_tx_wr_en = 1'b1;
      step();
      p_tx_wr_en = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (i == 8 * BIT + BIT / 2) par_seen = p_tx_line;
         if (p_rx_valid === 1'b1) begin
            got_valid = 1'b1;
            break;
         end
         step();
      end
      n_tests++;
      if (par_seen !== 1'b1) begin n_fail++; $display("FAIL par_bit: parity bit got %b want 1", par_seen); end
      n_tests++;
      if (!got_valid) begin n_fail++; $display("FAIL par_loop_timeout: rx_valid got 0 want 1"); end
      read_fifo(1, "par_loop");
      n_tests++;
      if (p_perr_cnt != pe0 || p_ferr_cnt != fe0) begin
         n_fail++; $display("FAIL par_loop_flags: err pulses got %0d/%0d want 0/0", p_perr_cnt - pe0, p_ferr_cnt - fe0);
      end
      repeat (BIT) step();
      p_loop = 1'b0;
   endtask

   task automatic test_parity_error();
      int pe0;
      pe0 = p_perr_cnt;
      // 0x55 has four ones: odd parity needs 1, send 0
      send_rx_frame(1, 9'h055, 7, 1'b1, 1'b0, 1'b1);
      repeat (20) step();
      n_tests++;
      if (p_perr_cnt - pe0 != 1) begin
         n_fail++; $display("FAIL par_err_pulse: rx_parity_err cycles got %0d want 1", p_perr_cnt - pe0);
      end
      n_tests++;
      if (p_rx_valid !== 1'b0) begin n_fail++; $display("FAIL par_err_discard: rx_valid got %b want 0", p_rx_valid); end
      // 0x2A has three ones: odd parity bit 0 is correct
      p_exp_q.push_back(9'h02A);
      send_rx_frame(1, 9'h02A, 7, 1'b1, 1'b0, 1'b1);
      read_fifo(1, "par_good");
   endtask

   task automatic test_false_start();
      int fe0, pe0;
      fe0 = ferr_cnt; pe0 = perr_cnt;
      rx_line = 1'b0;
      repeat (100) step();
      rx_line = 1'b1;
      repeat (1000) step();
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_push: rx_valid got %b want 0", rx_valid); end
      n_tests++;
      if (ferr_cnt != fe0 || perr_cnt != pe0) begin
         n_fail++; $display("FAIL false_start_flags: pulses got %0d/%0d want 0/0", ferr_cnt - fe0, perr_cnt - pe0);
      end
   endtask

   task automatic test_frame_error();
      int fe0;
      fe0 = ferr_cnt;
      send_rx_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
      repeat (500) step();
      n_tests++;
      if (ferr_cnt - fe0 != 1) begin
         n_fail++; $display("FAIL frame_err_pulse: rx_frame_err cycles got %0d want 1", ferr_cnt - fe0);
      end
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_err_discard: rx_valid got %b want 0", rx_valid); end
      // receiver must be back in IDLE and take the next frame normally
      rx_exp_q.push_back(9'h05A);
      send_rx_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
      read_fifo(0, "after_ferr");
   endtask

   task automatic test_back_to_back_overrun();
      int ov0;
      logic [7:0] frames [5];
      frames[0] = 8'h11; frames[1] = 8'h22; frames[2] = 8'h33;
      frames[3] = 8'h44; frames[4] = 8'h55;
      ov0 = ovr_cnt;
      for (int f = 0; f < 5; f++) begin
         if (f < 4) rx_exp_q.push_back(9'(frames[f]));
         send_rx_frame(0, 9'(frames[f]), 8, 1'b0, 1'b0, 1'b1);
      end
      repeat (50) step();
      n_tests++;
      if (ovr_cnt - ov0 != 1) begin
         n_fail++; $display("FAIL overrun_pulse: rx_overrun cycles got %0d want 1", ovr_cnt - ov0);
      end
      read_fifo(0, "overrun_read");
   endtask

   task automatic test_empty_pop();
      rx_rd_en = 1'b1;
      repeat (3) step();
      rx_rd_en = 1'b0;
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: rx_valid got %b want 0", rx_valid); end
      rx_exp_q.push_back(9'h081);
      send_rx_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b1);
      read_fifo(0, "empty_pop");
   endtask

   task automatic test_reset_midframe();
      int fe0;
      fe0 = ferr_cnt;
      fork
         send_rx_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b1);
         begin
            tx_data  = 8'h96;
            tx_wr_en = 1'b1;
            step();
            tx_wr_en = 1'b0;
            repeat (4 * BIT + 200) step();
            #3 rst_n = 1'b0;
            #1;
            n_tests++;
            if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
               n_fail++; $display("FAIL rst_mid_tx: Tx/tx_busy got %b/%b want 1/0", tx_line, tx_busy);
            end
         end
      join
      repeat (10) step();
      rst_n = 1'b1;
      repeat (1000) step();
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rx: rx_valid got %b want 0", rx_valid); end
      n_tests++;
      if (ferr_cnt != fe0) begin n_fail++; $display("FAIL rst_mid_flags: rx_frame_err cycles got %0d want 0", ferr_cnt - fe0); end
      test_tx_frame(8'hC3, 1'b0, "tx_after_rst");
   endtask

   initial begin
      test_reset();
      test_tx_frame(8'hA5, 1'b1, "tx_a5");
      test_parity_loopback();
      test_parity_error();
      test_false_start();
      test_frame_error();
      test_back_to_back_overrun();
      test_empty_pop();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9, payload bits per frame.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter RX_FIFO_DEPTH, default 4, power of two, 2..64.
REQ-007 clk_50m  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 tx_data  in  DATA_BITS  byte to transmit, LSB first.
REQ-010 tx_wr_en  in  1  one-cycle request to send tx_data.
REQ-011 tx_busy  out  1  high while a frame is in flight.
REQ-012 Tx  out  1  serial line, idle high.
REQ-013 Rx  in  1  asynchronous serial line, idle high.
REQ-014 rx_data  out  DATA_BITS  head of RX FIFO (show-ahead).
REQ-015 rx_valid  out  1  RX FIFO not empty.
REQ-016 rx_rd_en  in  1  pop RX FIFO head.
REQ-017 rx_frame_err / rx_parity_err / rx_overrun  out  1 each  one-cycle error pulses.

Function
REQ-018 Oversample tick SHALL fire once every DIV = round(CLK_HZ/(16*BAUD)) cycles; one bit = 16 ticks; DIV computed at elaboration, DIV < 2 is an elaboration error.
REQ-019 TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY = 0; STOP lasts STOP_BITS bit times; STOP -> IDLE.
REQ-020 tx_wr_en in IDLE SHALL latch tx_data, drive Tx low and assert tx_busy on the next clock edge; bit timer restarts at acceptance.
REQ-021 tx_wr_en while tx_busy SHALL be ignored; latched data is not altered.
REQ-022 tx_busy SHALL deassert on the edge the last stop bit completes; back-to-back writes on that cycle are accepted.
REQ-023 Rx SHALL pass a 2-flop synchroniser before use.
REQ-024 RX FSM states IDLE, START, DATA, PARITY, STOP; falling edge in IDLE -> START; line re-sampled at tick 8; high -> false start, back to IDLE, no flags.
REQ-025 Each data/parity/stop bit SHALL be sampled at tick 8 of its bit period; data shifted in LSB first.
REQ-026 Parity computed over DATA_BITS; mismatch -> rx_parity_err pulse, frame discarded.
REQ-027 First stop bit sampled low -> rx_frame_err pulse, frame discarded, FSM waits for line high before IDLE; second stop bit not checked by receiver.
REQ-028 Good frame SHALL be pushed to the FIFO on the cycle after the stop-bit sample.
REQ-029 Push when full and no pop -> frame dropped, rx_overrun pulse; push and pop same cycle when full -> both performed, no overrun.
REQ-030 rx_rd_en when empty SHALL be ignored; pointers wrap modulo RX_FIFO_DEPTH with an extra wrap bit for full/empty.
REQ-031 rx_data is undefined when rx_valid is low; valid the cycle after push.

Reset
REQ-032 While rst low: Tx = 1, tx_busy = 0, rx_valid = 0, all error pulses 0, both FSMs IDLE, FIFO empty, tick counter 0, synchroniser flops 1.
REQ-033 Reset asserted mid-frame SHALL abort both directions; no partial frame enters the FIFO.
REQ-034 After release, the receiver SHALL ignore Rx until a high-to-low transition is seen.

Structure
REQ-035 Shared package uart_pkg holds FSM state typedef, parity-mode constants and the divisor function.
REQ-036 RX FIFO SHALL be sub-module uart_fifo (parametrised width/depth); baud tick, TX and RX logic stay in uart_link.

Verification (defaults unless stated; DIV = 27, bit = 432 cycles)
REQ-037 tx_wr_en with 0xA5 -> Tx low 432 cycles, then 1,0,1,0,0,1,0,1, stop high; tx_busy high 4320 cycles.
REQ-038 PARITY=2, DATA_BITS=7, send 0x55 -> parity bit 1; loopback Tx->Rx yields rx_data 0x55, no flags.
REQ-039 Rx low pulse of 100 cycles -> no push, no flags, FSM back in IDLE.
REQ-040 Frame 0x3C with stop bit forced low -> rx_frame_err one pulse, rx_valid stays 0.
REQ-041 Five frames into depth-4 FIFO without reads -> rx_overrun once, four entries read in order.
REQ-042 rst low at bit 3 of a TX frame -> Tx high and tx_busy 0 within one cycle; next write transmits cleanly.
